// File: rtl/psum_drain_buffer.sv
// Per-lane psum row store at the array's south edge: overwrite or accumulate per K pass, then drain rows.
// Drain: first row valid the edge after collection completes, one row/cycle, rows held stable while out_ready=0.
module psum_drain_buffer #(
   parameter int COLS   = 8,
   parameter int PSUM_W = 32,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [ADDR_W:0]          num_rows,
   input  logic                     first_pass,
   input  logic                     last_pass,
   input  logic [COLS-1:0]          col_valid,
   input  logic [COLS*PSUM_W-1:0]   col_psum,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [COLS*PSUM_W-1:0]   out_data,
   output logic [ADDR_W-1:0]        out_row,
   output logic                     out_last,
   output logic                     busy,
   output logic                     done,
   output logic                     overflow_err
);

   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

   localparam logic [ADDR_W:0] MAX_ROWS = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);

   state_t state, state_nxt;

   logic [ADDR_W:0]    nrows;
   logic [ADDR_W:0]    nrows_in;
   logic               first_q;
   logic               last_q;
   logic [ADDR_W:0]    cnt [COLS];
   logic [ADDR_W-1:0]  rd_ptr;
   logic [PSUM_W-1:0]  mem [COLS][DEPTH];
   logic [PSUM_W-1:0]  lane_in [COLS];
   logic [COLS-1:0]    wr_en;
   logic [COLS-1:0]    excess;
   logic [COLS-1:0]    lane_full;
   logic               start_acc;
   logic               handshake;

   assign nrows_in  = (num_rows > MAX_ROWS) ? MAX_ROWS : num_rows;
   assign start_acc = start && (state == IDLE);
   assign handshake = out_valid && out_ready;

   // Lane completion looks ahead through this cycle's write so COLLECT exits on the same edge.
   always_comb begin
      for (int c = 0; c < COLS; c++) begin
         lane_in[c]   = col_psum[c*PSUM_W +: PSUM_W];
         wr_en[c]     = (state == COLLECT) && col_valid[c] && (cnt[c] < nrows);
         excess[c]    = (state != IDLE) && col_valid[c] && !wr_en[c];
         lane_full[c] = ((cnt[c] + {{ADDR_W{1'b0}}, wr_en[c]}) == nrows);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (nrows_in == '0) ? DONE : COLLECT;
         COLLECT: if (&lane_full) state_nxt = last_q ? DRAIN : DONE;
         DRAIN:   if (handshake && out_last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != IDLE);
      done      = (state == DONE);
      out_valid = (state == DRAIN);
      out_row   = out_valid ? rd_ptr : '0;
      out_last  = out_valid && ({1'b0, rd_ptr} == (nrows - ONE));
      for (int c = 0; c < COLS; c++)
         out_data[c*PSUM_W +: PSUM_W] = out_valid ? mem[c][rd_ptr] : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nrows        <= '0;
         first_q      <= 1'b0;
         last_q       <= 1'b0;
         rd_ptr       <= '0;
         overflow_err <= 1'b0;
         for (int c = 0; c < COLS; c++) cnt[c] <= '0;
      end else if (start_acc) begin
         nrows        <= nrows_in;
         first_q      <= first_pass;
         last_q       <= last_pass;
         rd_ptr       <= '0;
         overflow_err <= 1'b0;
         for (int c = 0; c < COLS; c++) cnt[c] <= '0;
      end else begin
         for (int c = 0; c < COLS; c++)
            if (wr_en[c]) cnt[c] <= cnt[c] + ONE;
         if (|excess) overflow_err <= 1'b1;
         if (handshake) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Buffer RAM is deliberately not reset.
   always_ff @(posedge clk) begin
      for (int c = 0; c < COLS; c++)
         if (wr_en[c])
            mem[c][cnt[c][ADDR_W-1:0]] <= first_q ? lane_in[c]
                                                  : mem[c][cnt[c][ADDR_W-1:0]] + lane_in[c];
   end

endmodule

// File: tb/tb_psum_drain_buffer.sv
// Bench for psum_drain_buffer: table of passes, hand-written corner sequences, randomized jobs vs an accumulator model.
module tb_psum_drain_buffer;
   localparam int COLS = 8, PSUM_W = 32, DEPTH = 16, ADDR_W = 4;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   start = 1'b0;
   logic [ADDR_W:0]        num_rows = '0;
   logic                   first_pass = 1'b0;
   logic                   last_pass = 1'b0;
   logic [COLS-1:0]        col_valid = '0;
   logic [COLS*PSUM_W-1:0] col_psum = '0;
   logic                   out_valid;
   logic                   out_ready = 1'b0;
   logic [COLS*PSUM_W-1:0] out_data;
   logic [ADDR_W-1:0]      out_row;
   logic                   out_last;
   logic                   busy;
   logic                   done;
   logic                   overflow_err;

   psum_drain_buffer #(.COLS(COLS), .PSUM_W(PSUM_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows),
      .first_pass(first_pass), .last_pass(last_pass), .col_valid(col_valid),
      .col_psum(col_psum), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_row(out_row), .out_last(out_last),
      .busy(busy), .done(done), .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [31:0] stim [COLS][DEPTH+4];
   int          nvalid [COLS];
   int          skew [COLS];
   logic [31:0] expw [COLS][DEPTH];
   logic [31:0] ref_acc [COLS][DEPTH];

   typedef struct {
      int          nr;
      bit          first;
      bit          last;
      logic [31:0] val;
      int          ready_mode;
      bit          exp_drain;
      int          exp_rows;
      logic [31:0] exp_word;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_pass(input int nr, input bit f, input bit l);
      num_rows   = (ADDR_W+1)'(nr);
      first_pass = f;
      last_pass  = l;
      start      = 1'b1;
      step();
      start      = 1'b0;
   endtask

   // Lane c presents its k-th value at cycle skew[c]+k; optionally pokes start mid-collection.
   task automatic feed(input bit inject_start);
      int last_cyc = 0;
      for (int c = 0; c < COLS; c++)
         if (skew[c] + nvalid[c] > last_cyc) last_cyc = skew[c] + nvalid[c];
      for (int cyc = 0; cyc < last_cyc; cyc++) begin
         for (int c = 0; c < COLS; c++) begin
            col_valid[c] = (cyc >= skew[c]) && (cyc - skew[c] < nvalid[c]);
            col_psum[c*PSUM_W +: PSUM_W] = col_valid[c] ? stim[c][cyc-skew[c]] : 32'h0;
         end
         if (inject_start && cyc == 1) begin
            start    = 1'b1;
            num_rows = 5'd1;
         end else begin
            start = 1'b0;
         end
         step();
         if (inject_start && cyc == 1) check("busy_after_ignored_start", busy, 1);
      end
      col_valid = '0;
      col_psum  = '0;
      start     = 1'b0;
   endtask

   // mode 0: ready held 1; mode 1: ready pattern 0,0,1; mode 2: random ready.
   task automatic drain(input int exp_rows, input int mode, input bit exp_ovf);
      int idx = 0;
      int waitc = 0;
      bit stalled = 0;
      logic [COLS*PSUM_W-1:0] pd;
      logic [ADDR_W-1:0] prow;
      while (idx < exp_rows && waitc < 400) begin
         waitc++;
         out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((waitc % 3) == 0) : 1'($urandom_range(0, 1));
         if (out_valid) begin
            if (stalled) begin
               check("stall_data_stable", 32'(out_data == pd), 1);
               check("stall_row_stable", 32'(out_row), 32'(prow));
            end
            if (out_ready) begin
               check($sformatf("row_index_%0d", idx), 32'(out_row), 32'(idx));
               check($sformatf("last_flag_row%0d", idx), out_last, 32'(idx == exp_rows - 1));
               for (int c = 0; c < COLS; c++)
                  check($sformatf("row%0d_lane%0d", idx, c), out_data[c*PSUM_W +: PSUM_W], expw[c][idx]);
               idx++;
               stalled = 0;
            end else begin
               stalled = 1;
               pd = out_data;
               prow = out_row;
            end
         end
         step();
      end
      out_ready = 1'b0;
      check("drain_rows_emitted", 32'(idx), 32'(exp_rows));
      check("done_after_drain", done, 1);
      check("no_valid_after_drain", out_valid, 0);
      check("overflow_at_done", overflow_err, 32'(exp_ovf));
      step();
      check("done_one_cycle", done, 0);
      check("idle_after_done", busy, 0);
   endtask

   task automatic wait_done();
      bit saw_valid = 0;
      for (int n = 0; n < 60 && !done; n++) begin
         if (out_valid) saw_valid = 1;
         step();
      end
      check("done_seen", done, 1);
      check("no_valid_nonlast_pass", 32'(saw_valid), 0);
      step();
      check("done_one_cycle_nl", done, 0);
   endtask

   initial begin
      vecs[0] = '{2,  1'b1, 1'b0, 32'd7,         0, 1'b0, 0,  32'd0};
      vecs[1] = '{2,  1'b0, 1'b1, 32'd5,         0, 1'b1, 2,  32'd12};
      vecs[2] = '{1,  1'b1, 1'b0, 32'hFFFF_FFF0, 0, 1'b0, 0,  32'd0};
      vecs[3] = '{1,  1'b0, 1'b1, 32'h20,        0, 1'b1, 1,  32'h10};
      vecs[4] = '{0,  1'b1, 1'b1, 32'd9,         0, 1'b0, 0,  32'd0};
      vecs[5] = '{20, 1'b1, 1'b1, 32'd3,         0, 1'b1, 16, 32'd3};
      vecs[6] = '{4,  1'b1, 1'b1, 32'hA5,        1, 1'b1, 4,  32'hA5};

      #12;
      check("reset_out_valid", out_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_overflow", overflow_err, 0);
      check("reset_out_data", out_data[31:0], 0);
      rst_n = 1'b1;
      step();

      // Single pass, skewed lanes, start poked mid-collection must be ignored.
      for (int c = 0; c < COLS; c++) begin
         skew[c] = c;
         nvalid[c] = 3;
         for (int r = 0; r < 3; r++) begin
            stim[c][r] = 32'(100 * r + c);
            expw[c][r] = 32'(100 * r + c);
         end
      end
      start_pass(3, 1, 1);
      check("busy_in_collect", busy, 1);
      feed(1);
      drain(3, 0, 0);

      // Table of passes.
      foreach (vecs[i]) begin
         for (int c = 0; c < COLS; c++) begin
            skew[c] = c % 4;
            nvalid[c] = (vecs[i].nr > DEPTH) ? DEPTH : vecs[i].nr;
            for (int r = 0; r < DEPTH; r++) begin
               stim[c][r] = vecs[i].val;
               expw[c][r] = vecs[i].exp_word;
            end
         end
         start_pass(vecs[i].nr, vecs[i].first, vecs[i].last);
         if (vecs[i].nr == 0) begin
            check("zero_rows_done", done, 1);
            check("zero_rows_no_valid", out_valid, 0);
            step();
            check("zero_rows_idle", busy, 0);
         end else begin
            feed(0);
            if (vecs[i].exp_drain) drain(vecs[i].exp_rows, vecs[i].ready_mode, 0);
            else wait_done();
         end
      end

      // Excess valids on lane 3: third value dropped, flag sticky until next start.
      for (int c = 0; c < COLS; c++) begin
         skew[c] = 0;
         nvalid[c] = (c == 3) ? 3 : 2;
         for (int r = 0; r < 3; r++) stim[c][r] = 32'(50 + r + 10 * c);
         for (int r = 0; r < 2; r++) expw[c][r] = 32'(50 + r + 10 * c);
      end
      start_pass(2, 1, 1);
      feed(0);
      check("overflow_set", overflow_err, 1);
      drain(2, 0, 1);
      check("overflow_sticky_idle", overflow_err, 1);
      start_pass(0, 1, 1);
      check("overflow_cleared_by_start", overflow_err, 0);
      step();

      // Reset in the middle of a drain.
      for (int c = 0; c < COLS; c++) begin
         skew[c] = 0;
         nvalid[c] = 3;
         for (int r = 0; r < 3; r++) stim[c][r] = 32'(r + 1);
      end
      start_pass(3, 1, 1);
      feed(0);
      check("drain_entered", out_valid, 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("row1_presented", 32'(out_row), 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_drain_valid", out_valid, 0);
      check("rst_mid_drain_busy", busy, 0);
      check("rst_mid_drain_done", done, 0);
      step();
      rst_n = 1'b1;
      step();

      // Randomized jobs: 1..3 passes each, model accumulates mod 2^32.
      for (int job = 0; job < 12; job++) begin
         int nr = $urandom_range(1, DEPTH);
         int passes = $urandom_range(1, 3);
         for (int p = 0; p < passes; p++) begin
            bit f = (p == 0);
            bit l = (p == passes - 1);
            bit ovf = 0;
            for (int c = 0; c < COLS; c++) begin
               skew[c] = $urandom_range(0, 3);
               nvalid[c] = nr;
               if (l && $urandom_range(0, 4) == 0) begin
                  nvalid[c] = nr + 1;
                  ovf = 1;
               end
               for (int r = 0; r < nvalid[c]; r++) stim[c][r] = $urandom;
               for (int r = 0; r < nr; r++)
                  ref_acc[c][r] = f ? stim[c][r] : ref_acc[c][r] + stim[c][r];
            end
            start_pass(nr, f, l);
            feed(0);
            if (l) begin
               for (int c = 0; c < COLS; c++)
                  for (int r = 0; r < nr; r++) expw[c][r] = ref_acc[c][r];
               drain(nr, 2, ovf);
            end else begin
               wait_done();
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete, expected completion");
      $fatal(1);
   end
endmodule
